// File: rtl/seg7_capture_if.sv
// rtl/seg7_capture_if.sv - segment/select bus and captured-frame outputs of seg7_capture
// dp_out exists only when SEG7_CAP_DP_EN is defined.
interface seg7_capture_if;
    logic [7:0]  seg_in;
    logic [5:0]  dig_sel;
    logic [23:0] data_out;
    logic        frame_valid;
    logic        frame_err;
`ifdef SEG7_CAP_DP_EN
    logic [5:0]  dp_out;

    modport master (output seg_in, dig_sel, input data_out, frame_valid, frame_err, dp_out);
    modport slave  (input seg_in, dig_sel, output data_out, frame_valid, frame_err, dp_out);
`else
    modport master (output seg_in, dig_sel, input data_out, frame_valid, frame_err);
    modport slave  (input seg_in, dig_sel, output data_out, frame_valid, frame_err);
`endif
endinterface

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - samples a multiplexed 7-segment bus and rebuilds 24-bit hex frames
// Optional decimal-point capture on dp_out is enabled by defining SEG7_CAP_DP_EN.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input logic           m_clock,
    input logic           p_reset,
    seg7_capture_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

    logic [13:0] sync_q [SYNC_STAGES];
    logic [13:0] sync_d [SYNC_STAGES];
    logic [5:0]  s_sel;
    logic [7:0]  s_seg;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  prev_sel_q, prev_sel_d;
    logic [6:0]  prev_seg_q, prev_seg_d;
    logic [5:0]  mask_q, mask_d;
    logic [5:0]  err_q, err_d;
    logic [23:0] nib_q, nib_d;
    logic [23:0] data_out_q, data_out_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_err_q, frame_err_d;
`ifdef SEG7_CAP_DP_EN
    logic [5:0]  dp_q, dp_d;
    logic [5:0]  dp_out_q, dp_out_d;
`else
    logic        unused_dp;
`endif

    logic        one_hot, same, capture;
    logic [7:0]  cnt_now;
    logic [3:0]  dec_nib;
    logic        dec_err;

    always_comb begin
        sync_d[0] = {bus.dig_sel, bus.seg_in};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign s_sel   = sync_q[SYNC_STAGES-1][13:8];
    assign s_seg   = sync_q[SYNC_STAGES-1][7:0];
    assign one_hot = (s_sel != 6'd0) && ((s_sel & (s_sel - 6'd1)) == 6'd0);
    // The dp line never takes part in stability, so a toggling dp cannot hold off capture.
    assign same    = (s_sel == prev_sel_q) && (s_seg[6:0] == prev_seg_q);
    // cnt_q holds how many identical samples have been seen; cnt_now includes this one.
    assign cnt_now = (state_q == SETTLE && same) ? cnt_q + 8'd1 : 8'd1;

    always_comb begin
        dec_nib = 4'h0;
        dec_err = 1'b0;
        case (s_seg[6:0])
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h27: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h38: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            default: dec_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        prev_sel_d    = s_sel;
        prev_seg_d    = s_seg[6:0];
        mask_d        = mask_q;
        err_d         = err_q;
        nib_d         = nib_q;
        data_out_d    = data_out_q;
        frame_valid_d = 1'b0;
        frame_err_d   = frame_err_q;
        capture       = 1'b0;
`ifdef SEG7_CAP_DP_EN
        dp_d          = dp_q;
        dp_out_d      = dp_out_q;
`endif
        if (!one_hot) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else if (state_q == HOLD && same) begin
            state_d = HOLD;
        end else if (cnt_now == STABLE_N) begin
            capture = 1'b1;
            state_d = HOLD;
            cnt_d   = 8'd0;
        end else begin
            state_d = SETTLE;
            cnt_d   = cnt_now;
        end

        if (capture) begin
            for (int i = 0; i < 6; i++) begin
                if (s_sel[i]) begin
                    nib_d[4*i +: 4] = dec_nib;
                    err_d[i]        = dec_err;
                    mask_d[i]       = 1'b1;
`ifdef SEG7_CAP_DP_EN
                    dp_d[i]         = s_seg[7];
`endif
                end
            end
            if ((mask_q | s_sel) == 6'h3F) begin
                data_out_d    = nib_d;
                frame_err_d   = |err_d;
                frame_valid_d = 1'b1;
                mask_d        = 6'd0;
                err_d         = 6'd0;
`ifdef SEG7_CAP_DP_EN
                dp_out_d      = dp_d;
`endif
            end
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 14'd0;
            end
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            prev_sel_q    <= 6'd0;
            prev_seg_q    <= 7'd0;
            mask_q        <= 6'd0;
            err_q         <= 6'd0;
            nib_q         <= 24'd0;
            data_out_q    <= 24'd0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
`ifdef SEG7_CAP_DP_EN
            dp_q          <= 6'd0;
            dp_out_q      <= 6'd0;
`endif
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prev_sel_q    <= prev_sel_d;
            prev_seg_q    <= prev_seg_d;
            mask_q        <= mask_d;
            err_q         <= err_d;
            nib_q         <= nib_d;
            data_out_q    <= data_out_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
`ifdef SEG7_CAP_DP_EN
            dp_q          <= dp_d;
            dp_out_q      <= dp_out_d;
`endif
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
`ifdef SEG7_CAP_DP_EN
    assign bus.dp_out      = dp_out_q;
`else
    assign unused_dp       = s_seg[7];
`endif
endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - randomized and directed scoreboard bench for seg7_capture
// Build with SEG7_CAP_DP_EN to also check dp_out.
module tb_seg7_capture;
    localparam int N = 4;
    localparam int S = 2;

    logic m_clock = 1'b0;
    logic p_reset = 1'b0;
    always #5 m_clock = ~m_clock;

    seg7_capture_if bus ();

    seg7_capture #(.STABLE_CYCLES(N), .SYNC_STAGES(S)) dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .bus     (bus)
    );

    typedef struct {
        logic [23:0] data;
        logic        err;
        logic [5:0]  dp;
    } frame_t;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h38, 7'h5E, 7'h79, 7'h71};

    logic [3:0] m_nib [6];
    logic [5:0] m_err  = '0;
    logic [5:0] m_dp   = '0;
    logic [5:0] m_mask = '0;
    frame_t     exp_q [$];

    int checks   = 0;
    int failures = 0;
    int lat;
    logic [5:0] last_sel = '0;
    logic [6:0] last_seg = '0;
    logic [7:0] scan_pat [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 6; k++) m_nib[k] = 4'h0;
        m_err  = '0;
        m_dp   = '0;
        m_mask = '0;
    endtask

    // Reference: look the pattern up in the table; a frame exists once all six digits are seen.
    task automatic model_capture(input int d, input logic [7:0] pat);
        logic [3:0] n;
        logic       e;
        frame_t     f;
        n = 4'h0;
        e = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (seg_tab[k] == pat[6:0]) begin
                n = 4'(k);
                e = 1'b0;
            end
        end
        m_nib[d]  = n;
        m_err[d]  = e;
        m_dp[d]   = pat[7];
        m_mask[d] = 1'b1;
        if (m_mask == 6'h3F) begin
            f.data = '0;
            for (int k = 0; k < 6; k++) f.data = f.data | (24'(m_nib[k]) << (4 * k));
            f.err  = |m_err;
            f.dp   = m_dp;
            exp_q.push_back(f);
            m_mask = '0;
            m_err  = '0;
        end
    endtask

    // Called at a falling edge; holds the value for cyc cycles.
    task automatic drive(input logic [5:0] sel, input logic [7:0] pat, input int cyc);
        bus.dig_sel = sel;
        bus.seg_in  = pat;
        last_sel    = sel;
        last_seg    = pat[6:0];
        if ($countones(sel) == 1 && cyc >= N) begin
            for (int k = 0; k < 6; k++) if (sel[k]) model_capture(k, pat);
        end
        repeat (cyc) @(negedge m_clock);
    endtask

    task automatic scan(input int cyc);
        for (int k = 0; k < 6; k++) drive(6'(1 << k), scan_pat[k], cyc);
        drive(6'd0, 8'h00, 10);
    endtask

    always @(negedge m_clock) begin
        if (p_reset && bus.frame_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame actual=%0h required=no_frame at %0t", bus.data_out, $time);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                chk("frame_data", 32'(bus.data_out), 32'(f.data));
                chk("frame_err", 32'(bus.frame_err), 32'(f.err));
`ifdef SEG7_CAP_DP_EN
                chk("frame_dp", 32'(bus.dp_out), 32'(f.dp));
`endif
            end
        end
    end

    initial begin
        model_reset();
        bus.seg_in  = 8'h00;
        bus.dig_sel = 6'd0;
        #1;
        chk("reset_data", 32'(bus.data_out), 32'h0);
        chk("reset_valid", 32'(bus.frame_valid), 32'h0);
        chk("reset_err", 32'(bus.frame_err), 32'h0);
        repeat (3) @(negedge m_clock);
        p_reset = 1'b1;

        // nominal scan
        scan_pat = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D};
        scan(8);
        chk("nominal_data", 32'(bus.data_out), 32'h543210);
        chk("nominal_err", 32'(bus.frame_err), 32'h0);

        // glitch restart, with digit 2 completing the frame so the latency is visible
        drive(6'h01, 8'h3F, 6); drive(6'h02, 8'h06, 6); drive(6'h08, 8'h4F, 6);
        drive(6'h10, 8'h66, 6); drive(6'h20, 8'h6D, 6); drive(6'h00, 8'h00, 5);
        drive(6'h04, 8'h7F, 3);
        drive(6'h04, 8'h7D, 0);
        model_capture(2, 8'h7D);
        lat = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(posedge m_clock);
            #1;
            if (bus.frame_valid) lat = k;
        end
        chk("glitch_latency", 32'(lat), 32'(S + N));
        @(negedge m_clock);
        repeat (4) @(negedge m_clock);
        chk("glitch_nibble", 32'(bus.data_out[11:8]), 32'h6);
        drive(6'h00, 8'h00, 5);

        // blanking and multi-select must not touch the mask for digits 0 and 1
        drive(6'h04, 8'h5B, 6); drive(6'h08, 8'h4F, 6); drive(6'h10, 8'h66, 6); drive(6'h20, 8'h6D, 6);
        drive(6'h00, 8'h3F, 20);
        drive(6'h03, 8'h06, 20);
        drive(6'h01, 8'h06, 6); drive(6'h02, 8'h3F, 6); drive(6'h00, 8'h00, 10);
        chk("blank_data", 32'(bus.data_out), 32'h543201);

        // bad pattern on digit 4
        scan_pat = '{8'h71, 8'h79, 8'h5E, 8'h38, 8'h00, 8'h77};
        scan(8);
        chk("bad_data", 32'(bus.data_out), 32'hA0CDEF);
        chk("bad_err", 32'(bus.frame_err), 32'h1);

        // repeat and out-of-order
        drive(6'h20, 8'h6D, 6); drive(6'h08, 8'h66, 6); drive(6'h08, 8'h4F, 6);
        drive(6'h01, 8'h3F, 6); drive(6'h02, 8'h06, 6); drive(6'h04, 8'h5B, 6);
        drive(6'h10, 8'h66, 6); drive(6'h00, 8'h00, 10);
        chk("order_data", 32'(bus.data_out), 32'h543210);

`ifdef SEG7_CAP_DP_EN
        scan_pat = '{8'h3F, 8'h86, 8'h5B, 8'h4F, 8'hE6, 8'h6D};
        scan(8);
        chk("dp_bits", 32'(bus.dp_out), 32'h12);
`endif

        // asynchronous reset after four captured digits
        drive(6'h01, 8'h06, 6); drive(6'h02, 8'h5B, 6); drive(6'h04, 8'h4F, 6); drive(6'h08, 8'h66, 6);
        drive(6'h00, 8'h00, 5);
        #2 p_reset = 1'b0;
        model_reset();
        #1;
        chk("async_reset_data", 32'(bus.data_out), 32'h0);
        chk("async_reset_valid", 32'(bus.frame_valid), 32'h0);
        chk("async_reset_err", 32'(bus.frame_err), 32'h0);
        @(negedge m_clock);
        @(negedge m_clock);
        p_reset = 1'b1;
        drive(6'h10, 8'h6D, 6); drive(6'h20, 8'h7D, 6); drive(6'h00, 8'h00, 10);
        chk("post_reset_no_frame", 32'(bus.data_out), 32'h0);
        scan_pat = '{8'h27, 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h38};
        scan(7);

        // randomized segments; consecutive segments always differ so each stands alone
        for (int i = 0; i < 300; i++) begin
            logic [5:0] sel;
            logic [7:0] pat;
            int         r;
            do begin
                r = $urandom_range(0, 9);
                if (r < 8)       sel = 6'(1 << $urandom_range(0, 5));
                else if (r == 8) sel = 6'd0;
                else             sel = 6'($urandom);
                if ($urandom_range(0, 3) != 0) pat = {1'($urandom), seg_tab[$urandom_range(0, 15)]};
                else                           pat = 8'($urandom);
            end while (sel == last_sel && pat[6:0] == last_seg);
            drive(sel, pat, ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, N - 1))
                                                        : int'($urandom_range(N, N + 6)));
        end
        drive(6'd0, 8'h00, 20);
        chk("pending_frames", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
